// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch unit and its slot queue.
//   XLEN_DEFAULT : default PC / instruction width
//   NOP_INST     : instruction presented to decode when nothing is valid (addi x0,x0,0)
//   cnt_w()      : width of a counter that must hold 0..depth inclusive
package fetch_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Icache request/response bundle between the fetch unit and the icache.
//   icache_req_valid/ready/addr : request channel, valid/ready handshake
//   icache_resp_valid/data      : in-order response channel, no backpressure
// master = fetch unit side, slave = icache side.
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);

    logic            icache_req_valid;
    logic            icache_req_ready;
    logic [XLEN-1:0] icache_req_addr;
    logic            icache_resp_valid;
    logic [XLEN-1:0] icache_resp_data;

    modport master (
        output icache_req_valid,
        output icache_req_addr,
        input  icache_req_ready,
        input  icache_resp_valid,
        input  icache_resp_data
    );

    modport slave (
        input  icache_req_valid,
        input  icache_req_addr,
        output icache_req_ready,
        output icache_resp_valid,
        output icache_resp_data
    );

endinterface

// File: rtl/fetch_slot_queue.sv
// Circular slot queue holding in-flight and returned fetches.
// A slot is allocated when a request issues, filled when its response
// returns (responses are in order, so fill_ptr just trails alloc_ptr) and
// freed when decode dequeues it.
//   clk, reset          : clock, synchronous active-low reset
//   alloc_i, alloc_pc_i : allocate slot at alloc_ptr with this PC
//   fill_i, fill_data_i : write response into slot at fill_ptr
//   deq_i               : free the head slot
//   flush_i             : drop everything, pointers back to 0
//   head_*_o            : head slot filled flag, PC and instruction
//   alloc_cnt_o         : allocated slots
//   unfilled_cnt_o      : allocated slots still waiting for a response
module fetch_slot_queue
    import fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alloc_i,
    input  logic [XLEN-1:0]            alloc_pc_i,
    input  logic                       fill_i,
    input  logic [XLEN-1:0]            fill_data_i,
    input  logic                       deq_i,
    input  logic                       flush_i,
    output logic                       head_filled_o,
    output logic [XLEN-1:0]            head_pc_o,
    output logic [XLEN-1:0]            head_data_o,
    output logic [$clog2(DEPTH+1)-1:0] alloc_cnt_o,
    output logic [$clog2(DEPTH+1)-1:0] unfilled_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]    alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0]    fill_ptr_q, fill_ptr_d;
    logic [PW-1:0]    head_ptr_q, head_ptr_d;
    logic [CW-1:0]    alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0]    filled_num;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        alloc_ptr_d = alloc_ptr_q + PW'(alloc_i);
        fill_ptr_d  = fill_ptr_q + PW'(fill_i);
        head_ptr_d  = head_ptr_q + PW'(deq_i);
        alloc_cnt_d = alloc_cnt_q + CW'(alloc_i) - CW'(deq_i);

        // alloc, fill and deq always target three different slots, so the
        // order of these updates does not matter.
        filled_d = filled_q;
        if (alloc_i) filled_d[alloc_ptr_q] = 1'b0;
        if (fill_i)  filled_d[fill_ptr_q]  = 1'b1;
        if (deq_i)   filled_d[head_ptr_q]  = 1'b0;
    end

    // Filled bits are only ever set on allocated slots and are cleared on
    // dequeue, so their population count is the filled part of alloc_cnt.
    always_comb begin
        filled_num = '0;
        for (int i = 0; i < DEPTH; i++) begin
            filled_num = filled_num + CW'(filled_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush_i) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            alloc_cnt_q <= '0;
            filled_q    <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            alloc_cnt_q <= alloc_cnt_d;
            filled_q    <= filled_d;
        end
    end

    // Payload storage needs no reset: the filled bits qualify it.
    always_ff @(posedge clk) begin
        if (alloc_i) pc_q[alloc_ptr_q]  <= alloc_pc_i;
        if (fill_i)  data_q[fill_ptr_q] <= fill_data_i;
    end

    assign head_filled_o  = filled_q[head_ptr_q] && (alloc_cnt_q != '0);
    assign head_pc_o      = pc_q[head_ptr_q];
    assign head_data_o    = data_q[head_ptr_q];
    assign alloc_cnt_o    = alloc_cnt_q;
    assign unfilled_cnt_o = alloc_cnt_q - filled_num;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: generates sequential PCs, issues pipelined icache
// requests under a credit limit, buffers up to DEPTH instructions and hands
// them to decode. A redirect flushes everything and counts the responses
// still owed by the icache so they can be discarded as they return.
//   clk, reset                 : clock, synchronous active-low reset
//   redirect_valid/redirect_pc : flush and restart at redirect_pc (word aligned)
//   icache                     : request/response bundle (master side)
//   inst_valid/inst_ready      : decode handshake
//   inst, inst_pc              : head instruction and its PC (NOP / 0 when idle)
//   inflight                   : allocated slots plus responses still to drop
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 'h0000_2000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    fetch_unit_if.master               icache,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [XLEN-1:0]            inst,
    output logic [XLEN-1:0]            inst_pc,
    output logic [$clog2(DEPTH+1)-1:0] inflight
);

    localparam int CW = cnt_w(DEPTH);
    localparam int SW = CW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   alloc_cnt, unfilled_cnt;
    logic            head_filled;
    logic [XLEN-1:0] head_pc, head_data;
    logic [SW-1:0]   used;
    logic            credit_ok, issue, fill, deq;
    logic            unused_pc_lsbs;

    assign unused_pc_lsbs = &{1'b0, redirect_pc[1:0]};

    // Every slot and every response still to be dropped costs a credit, so
    // drop_cnt can never exceed DEPTH.
    assign used      = SW'(alloc_cnt) + SW'(drop_cnt_q);
    assign credit_ok = used < SW'(DEPTH);

    assign icache.icache_req_valid = reset && credit_ok && !redirect_valid;
    assign icache.icache_req_addr  = fetch_pc_q;

    assign issue = icache.icache_req_valid && icache.icache_req_ready;
    // A response in a redirect cycle is old-stream; it is never written.
    assign fill  = reset && icache.icache_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
    assign deq   = inst_valid && inst_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    // On redirect every unfilled slot becomes a future drop; the response
    // arriving in the same cycle is already one of them (or fills a flushed
    // slot), hence the minus one.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            drop_cnt_d = drop_cnt_q + unfilled_cnt - CW'(icache.icache_resp_valid);
        end else if (icache.icache_resp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_slot_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_slots (
        .clk            (clk),
        .reset          (reset),
        .alloc_i        (issue),
        .alloc_pc_i     (fetch_pc_q),
        .fill_i         (fill),
        .fill_data_i    (icache.icache_resp_data),
        .deq_i          (deq),
        .flush_i        (redirect_valid),
        .head_filled_o  (head_filled),
        .head_pc_o      (head_pc),
        .head_data_o    (head_data),
        .alloc_cnt_o    (alloc_cnt),
        .unfilled_cnt_o (unfilled_cnt)
    );

    // Outputs are forced idle while reset is held, before state has settled.
    assign inst_valid = reset && head_filled;
    assign inst       = inst_valid ? head_data : XLEN'(NOP_INST);
    assign inst_pc    = inst_valid ? head_pc : '0;
    assign inflight   = reset ? (alloc_cnt + drop_cnt_q) : '0;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor of the single-entry Stage 1 fetch path.
- Generates sequential fetch PCs and issues pipelined requests to the icache over a valid/ready interface with variable, in-order response latency.
- Buffers up to DEPTH instructions with their PCs and presents them to decode through a valid/ready handshake.
- On a redirect (branch/jump resolved downstream), flushes all buffered and in-flight work and discards stale responses still returning from the icache.

Parameters:
- XLEN, 32, width of PC and instruction.
- DEPTH, 4, slot-queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_2000, first fetch address after reset.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-low reset.
- redirect_valid, input, 1, flush and restart fetch at redirect_pc.
- redirect_pc, input, XLEN, new fetch address; bits [1:0] are ignored and treated as 0.
- icache_req_valid, output, 1, request valid.
- icache_req_ready, input, 1, icache accepts request.
- icache_req_addr, output, XLEN, request address.
- icache_resp_valid, input, 1, response returned; in order; no backpressure.
- icache_resp_data, input, XLEN, instruction word.
- inst_valid, output, 1, head instruction available to decode.
- inst_ready, input, 1, decode accepts; low means stall.
- inst, output, XLEN, head instruction; NOP 32'h0000_0013 when inst_valid=0.
- inst_pc, output, XLEN, PC of head; 0 when inst_valid=0.
- inflight, output, clog2(DEPTH+1), allocated slots plus pending drops (debug/perf).

Behaviour:
- Reset (reset==0 at a clk edge):
  - fetch_pc = RESET_PC; all slots empty; alloc_cnt = 0; drop_cnt = 0.
  - Outputs while in reset: icache_req_valid=0, inst_valid=0, inst=NOP, inst_pc=0, inflight=0.
  - Reset asserted mid-operation abandons all state. Responses arriving in the cycles after reset release are not dropped; the icache is reset on the same reset, so none are outstanding.
- Slot queue:
  - Circular; pointers alloc_ptr, fill_ptr, head_ptr. Each slot holds pc, data and a filled bit.
  - A slot is allocated at request issue, filled at response, and freed at dequeue.
- Issue:
  - icache_req_valid = (alloc_cnt + drop_cnt < DEPTH) && !redirect_valid.
  - icache_req_addr = fetch_pc.
  - On handshake: slot[alloc_ptr].pc = fetch_pc, filled=0, alloc_ptr++, alloc_cnt++, fetch_pc += 4 (wraps mod 2^XLEN).
- Response (icache_resp_valid):
  - If drop_cnt>0: discard and decrement drop_cnt.
  - Else: slot[fill_ptr].data = resp, filled=1, fill_ptr++.
- Output:
  - inst_valid = slot[head_ptr].filled && alloc_cnt>0.
  - Dequeue on inst_valid && inst_ready: head_ptr++, alloc_cnt--.
  - The head instruction is visible the cycle after its response arrives (1-cycle fill latency). There is no combinational bypass from icache_resp to inst.
- Simultaneous events in one cycle:
  - Issue, fill and dequeue may all occur; alloc_cnt changes by (+issue) - (deq).
- Redirect (highest priority):
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - All slots are invalidated; alloc_ptr = fill_ptr = head_ptr = 0; alloc_cnt = 0.
  - unfilled = number of allocated slots with filled=0. New drop_cnt = drop_cnt + unfilled - (icache_resp_valid ? 1 : 0).
  - A response in the redirect cycle always belongs to the old stream and is discarded: it either consumes one drop or fills a slot that is being flushed.
  - A dequeue handshake in the redirect cycle counts as consumed by decode.
  - No request is issued in the redirect cycle. The first new-stream request goes out the next cycle, when the credit check passes.
  - Back-to-back redirects accumulate drop_cnt. drop_cnt never exceeds DEPTH because issue is credit-limited.
- Full: alloc_cnt + drop_cnt == DEPTH blocks issue. The issue request deasserts and fetch_pc holds.
- Empty: inst_valid=0 and NOP is driven; decode sees a bubble.
- icache_resp_valid with no outstanding request is illegal; the implementation may assert on it in simulation.

Decomposition:
- Shared package fetch_pkg holds XLEN_DEFAULT, NOP_INST = 32'h0000_0013, and the clog2-derived count width function.
- Sub-module fetch_slot_queue owns the slot storage, the three pointers, the filled bits and the flush. It exposes alloc, fill, deq, flush, head data/pc/filled, alloc_cnt and unfilled_cnt.
- The top level owns fetch_pc, drop_cnt, the credit check and the output muxing.

Test Plan:
- Reset, then icache ready with fixed 1-cycle latency, inst_ready=1:
  - requests go out to 0x2000, 0x2004, 0x2008, ... on consecutive cycles;
  - inst_pc follows the same sequence with instructions matching;
  - sustained throughput is 1 instruction per cycle.
- inst_ready=0 for 10 cycles: exactly DEPTH=4 requests are issued, then icache_req_valid=0. Release inst_ready: four instructions dequeue in order 0x2000..0x200C and issue resumes at 0x2010.
- Icache latency 3, three requests outstanding, redirect_pc=0x3002:
  - the next request address is 0x3000;
  - the three old responses are dropped (inflight decrements to the new-stream count);
  - the first delivered inst_pc is 0x3000.
- A redirect in the same cycle as an icache response and a decode dequeue: the response is discarded, drop_cnt = unfilled - 1, and the queue is empty the next cycle.
- Two redirects 1 cycle apart (0x4000, then 0x5000) with latency 4: only the instruction at 0x5000 and its successors ever reach inst_valid=1.
- Assert reset low for one cycle mid-stream with slots filled: the next cycle has inst_valid=0, inst=0x0000_0013, inflight=0, and the first request goes to 0x2000.
